// File: rtl/neuron_lut_scheduler_if.sv
// Stream, result and configuration ports of the time-multiplexed
// LogicNets neuron layer.
interface neuron_lut_scheduler_if #(
  parameter int IN_FEATURES = 32,
  parameter int IN_BW       = 2,
  parameter int FANIN       = 3,
  parameter int OUT_BW      = 2,
  parameter int N_NEURONS   = 16
);
  localparam int A  = FANIN * IN_BW;
  localparam int NW = $clog2(N_NEURONS);
  // One spare index bit so out-of-range connections are expressible
  localparam int IW = $clog2(IN_FEATURES) + 1;
  localparam int WD = (OUT_BW > IW) ? OUT_BW : IW;

  logic                          s_valid;
  logic                          s_ready;
  logic [IN_FEATURES*IN_BW-1:0]  s_data;
  logic                          m_valid;
  logic                          m_ready;
  logic [N_NEURONS*OUT_BW-1:0]   m_data;
  logic                          cfg_we;
  logic                          cfg_sel;
  logic [NW+A-1:0]               cfg_addr;
  logic [WD-1:0]                 cfg_wdata;
  logic                          cfg_ready;
  logic                          busy;

  modport master (
    output s_valid, s_data, m_ready,
    output cfg_we, cfg_sel, cfg_addr, cfg_wdata,
    input  s_ready, m_valid, m_data,
    input  cfg_ready, busy
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    input  cfg_we, cfg_sel, cfg_addr, cfg_wdata,
    output s_ready, m_valid, m_data,
    output cfg_ready, busy
  );
endinterface

// File: rtl/neuron_lut_scheduler.sv
// Shared runtime-programmable truth table evaluated one neuron
// per cycle over a latched feature vector.
module neuron_lut_scheduler #(
  parameter int IN_FEATURES = 32,
  parameter int IN_BW       = 2,
  parameter int FANIN       = 3,
  parameter int OUT_BW      = 2,
  parameter int N_NEURONS   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  neuron_lut_scheduler_if.slave   bus
);
  localparam int A  = FANIN * IN_BW;
  localparam int NW = $clog2(N_NEURONS);
  localparam int IW = $clog2(IN_FEATURES) + 1;
  localparam int FW = $clog2(IN_FEATURES);
  localparam int SW = $clog2(FANIN);
  localparam logic [NW-1:0] LAST = NW'(N_NEURONS - 1);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [NW-1:0]                cnt_q, cnt_d;
  logic [IN_FEATURES*IN_BW-1:0] feat_q, feat_d;
  logic [N_NEURONS*OUT_BW-1:0]  out_q, out_d;
  logic [N_NEURONS*OUT_BW-1:0]  mdat_q, mdat_d;

  logic [OUT_BW-1:0] lut_mem  [N_NEURONS][2**A];
  logic [IW-1:0]     conn_mem [N_NEURONS][FANIN];

  logic [A-1:0]      addr;
  logic [OUT_BW-1:0] lut_rd;
  logic [IW-1:0]     idx;
  logic [FW-1:0]     fi;

  logic              cfg_ok;
  logic              lut_wr;
  logic              conn_wr;
  logic [NW-1:0]     l_nrn;
  logic [A-1:0]      l_ent;
  logic [NW-1:0]     c_nrn;
  logic [SW-1:0]     c_slot;

  // Gather the fan-in features; slot 0 lands in the address LSBs
  always_comb begin
    addr = '0;
    idx  = '0;
    fi   = '0;
    for (int k = 0; k < FANIN; k++) begin
      idx = conn_mem[cnt_q][k];
      fi  = idx[FW-1:0];
      if (int'(idx) < IN_FEATURES) begin
        addr[k*IN_BW +: IN_BW] =
          feat_q[int'(fi)*IN_BW +: IN_BW];
      end
    end
    lut_rd = lut_mem[cnt_q][addr];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    feat_d  = feat_q;
    out_d   = out_q;
    mdat_d  = mdat_q;
    unique case (state_q)
      IDLE: begin
        if (bus.s_valid) begin
          feat_d  = bus.s_data;
          cnt_d   = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        out_d[cnt_q*OUT_BW +: OUT_BW] = lut_rd;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          mdat_d  = out_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.m_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      feat_q  <= '0;
      out_q   <= '0;
      mdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      feat_q  <= feat_d;
      out_q   <= out_d;
      mdat_q  <= mdat_d;
    end
  end

  assign cfg_ok  = (state_q == IDLE);
  assign l_nrn   = bus.cfg_addr[A +: NW];
  assign l_ent   = bus.cfg_addr[A-1:0];
  assign c_nrn   = bus.cfg_addr[SW +: NW];
  assign c_slot  = bus.cfg_addr[SW-1:0];
  assign lut_wr  = bus.cfg_we && cfg_ok && !bus.cfg_sel;
  assign conn_wr = bus.cfg_we && cfg_ok && bus.cfg_sel
                && (int'(c_slot) < FANIN);

  // Tables are plain storage and survive reset
  always_ff @(posedge clk) begin
    unique case (1'b1)
      lut_wr:
        lut_mem[l_nrn][l_ent] <= bus.cfg_wdata[OUT_BW-1:0];
      conn_wr:
        conn_mem[c_nrn][c_slot] <= bus.cfg_wdata[IW-1:0];
      default: ;
    endcase
  end

  assign bus.s_ready   = (state_q == IDLE);
  assign bus.cfg_ready = cfg_ok;
  assign bus.m_valid   = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.m_data    = mdat_q;

endmodule

// File: tb/tb_neuron_lut_scheduler.sv
// Randomised bench for neuron_lut_scheduler against a
// table-lookup reference model.
module tb_neuron_lut_scheduler;
  localparam int IN_FEATURES = 32;
  localparam int IN_BW       = 2;
  localparam int FANIN       = 3;
  localparam int OUT_BW      = 2;
  localparam int N_NEURONS   = 16;
  localparam int A           = FANIN * IN_BW;
  localparam int NE          = 2**A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_lut_scheduler_if #(
    .IN_FEATURES(IN_FEATURES), .IN_BW(IN_BW), .FANIN(FANIN),
    .OUT_BW(OUT_BW), .N_NEURONS(N_NEURONS)
  ) bus ();

  neuron_lut_scheduler #(
    .IN_FEATURES(IN_FEATURES), .IN_BW(IN_BW), .FANIN(FANIN),
    .OUT_BW(OUT_BW), .N_NEURONS(N_NEURONS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_q[$];
  logic [31:0] got_q[$];
  int lut_m  [N_NEURONS][NE];
  int conn_m [N_NEURONS][FANIN];

  always @(posedge clk) begin
    cyc++;
    if (bus.s_valid && bus.s_ready) acc_q.push_back(cyc);
    if (bus.m_valid && bus.m_ready) got_q.push_back(bus.m_data);
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_lut(int n, int a, int v);
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = 1'b0;
    bus.cfg_addr  = {4'(n), 6'(a)};
    bus.cfg_wdata = 6'(v);
    tick();
    bus.cfg_we = 1'b0;
    lut_m[n][a] = v;
  endtask

  task automatic wr_conn(int n, int k, int i);
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = 1'b1;
    bus.cfg_addr  = '0;
    bus.cfg_addr[5:0] = {4'(n), 2'(k)};
    bus.cfg_wdata = 6'(i);
    tick();
    bus.cfg_we = 1'b0;
    conn_m[n][k] = i;
  endtask

  function automatic int addr_of(int n, logic [63:0] d);
    int a;
    int i;
    int f;
    a = 0;
    for (int k = 0; k < FANIN; k++) begin
      i = conn_m[n][k];
      f = 0;
      if (i < IN_FEATURES) f = int'(d[i*IN_BW +: IN_BW]);
      a = a + f * (4 ** k);
    end
    return a;
  endfunction

  function automatic logic [31:0] model(logic [63:0] d);
    logic [31:0] r;
    r = '0;
    for (int n = 0; n < N_NEURONS; n++)
      r[n*OUT_BW +: OUT_BW] = 2'(lut_m[n][addr_of(n, d)]);
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic prog_random();
    for (int n = 0; n < N_NEURONS; n++)
      for (int a = 0; a < NE; a++)
        wr_lut(n, a, $urandom_range(0, 3));
    for (int n = 0; n < N_NEURONS; n++)
      for (int k = 0; k < FANIN; k++)
        wr_conn(n, k, $urandom_range(0, IN_FEATURES - 1));
  endtask

  task automatic send(logic [63:0] d);
    int n0;
    n0 = acc_q.size();
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 60 && acc_q.size() == n0; i++) tick();
    bus.s_valid = 1'b0;
    if (acc_q.size() == n0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_mvalid();
    for (int i = 0; i < 40 && !bus.m_valid; i++) tick();
    if (!bus.m_valid) chk("mvalid_timeout", 0, 1);
  endtask

  task automatic drain(string tag, logic [31:0] exp);
    int n0;
    n0 = got_q.size();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 40 && got_q.size() == n0; i++) tick();
    bus.m_ready = 1'b0;
    if (got_q.size() == n0) chk({tag, "_timeout"}, 0, 1);
    else chk(tag, got_q[$], exp);
    chk({tag, "_idle"}, {bus.s_ready, bus.m_valid}, 2'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [63:0] d2;
    logic [31:0] e;
    int a0;
    int lat;
    int n0;
    int g0;
    int ea;

    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_sel = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_wdata = '0;

    #12;
    chk("rst_s_ready", bus.s_ready, 1'b1);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_data", bus.m_data, 32'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_cfg_ready", bus.cfg_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    prog_random();

    // Single-minterm neuron 0 and latency
    for (int a = 0; a < NE; a++) wr_lut(0, a, (a == 5) ? 1 : 0);
    wr_conn(0, 0, 0);
    wr_conn(0, 1, 1);
    wr_conn(0, 2, 2);
    d = rnd64();
    d[5:0] = 6'b000101;
    send(d);
    a0 = acc_q[$];
    chk("eval_busy", {bus.busy, bus.s_ready}, 2'b10);
    wait_mvalid();
    lat = cyc - a0;
    chk("latency", lat, 16);
    chk("n0_minterm", bus.m_data[1:0], 2'b01);
    drain("vec_minterm", model(d));

    // Identity LUTs with self-connections
    for (int n = 0; n < N_NEURONS; n++) begin
      for (int a = 0; a < NE; a++) wr_lut(n, a, a % 4);
      for (int k = 0; k < FANIN; k++) wr_conn(n, k, n);
    end
    for (int f = 0; f < IN_FEATURES; f++) d[f*2 +: 2] = 2'(f % 4);
    e = '0;
    for (int n = 0; n < N_NEURONS; n++) e[n*2 +: 2] = 2'(n % 4);
    send(d);
    wait_mvalid();
    chk("ident_data", bus.m_data, e);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", {bus.m_valid, bus.s_ready}, 2'b10);
      chk("hold_data", bus.m_data, e);
    end
    drain("ident_drain", e);

    // Random tables and vectors, random output stalls
    prog_random();
    for (int v = 0; v < 6; v++) begin
      d = rnd64();
      send(d);
      wait_mvalid();
      for (int i = $urandom_range(0, 6); i > 0; i--) tick();
      drain("rand_vec", model(d));
    end

    // Back-to-back with m_ready tied high
    d = rnd64();
    d2 = rnd64();
    n0 = acc_q.size();
    g0 = got_q.size();
    bus.m_ready = 1'b1;
    bus.s_data = d;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 60 && acc_q.size() == n0; i++) tick();
    bus.s_data = d2;
    for (int i = 0; i < 60 && acc_q.size() < n0 + 2; i++) tick();
    bus.s_valid = 1'b0;
    for (int i = 0; i < 60 && got_q.size() < g0 + 2; i++) tick();
    bus.m_ready = 1'b0;
    if (acc_q.size() < n0 + 2 || got_q.size() < g0 + 2) begin
      chk("b2b_timeout", 0, 1);
    end else begin
      chk("b2b_spacing", acc_q[n0+1] - acc_q[n0], 18);
      chk("b2b_first", got_q[g0], model(d));
      chk("b2b_second", got_q[g0+1], model(d2));
    end

    // Configuration writes during EVAL are dropped
    d = rnd64();
    e = model(d);
    ea = addr_of(0, d);
    send(d);
    chk("eval_cfg_ready", bus.cfg_ready, 1'b0);
    bus.cfg_we = 1'b1;
    bus.cfg_sel = 1'b0;
    bus.cfg_addr = {4'd0, 6'(ea)};
    bus.cfg_wdata = 6'((lut_m[0][ea] + 1) % 4);
    for (int i = 0; i < 3; i++) tick();
    bus.cfg_we = 1'b0;
    drain("eval_cfg_vec", e);
    send(d);
    drain("eval_cfg_again", e);

    // Out-of-range connection indices read zero
    wr_conn(3, 1, 40);
    wr_conn(5, 2, 63);
    for (int v = 0; v < 3; v++) begin
      d = rnd64();
      send(d);
      drain("oor_vec", model(d));
    end

    // Config write and vector acceptance on the same edge
    d = rnd64();
    ea = addr_of(3, d);
    n0 = acc_q.size();
    bus.s_data = d;
    bus.s_valid = 1'b1;
    bus.cfg_we = 1'b1;
    bus.cfg_sel = 1'b0;
    bus.cfg_addr = {4'd3, 6'(ea)};
    bus.cfg_wdata = 6'((lut_m[3][ea] + 1) % 4);
    lut_m[3][ea] = (lut_m[3][ea] + 1) % 4;
    tick();
    bus.s_valid = 1'b0;
    bus.cfg_we = 1'b0;
    chk("same_edge_accept", acc_q.size(), n0 + 1);
    drain("same_edge_vec", model(d));

    // Reset in the middle of EVAL
    d = rnd64();
    send(d);
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", {bus.m_valid, bus.s_ready, bus.busy}, 3'b010);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {bus.m_valid, bus.s_ready}, 2'b01);
    chk("post_rst_data", bus.m_data, 32'h0);
    d = rnd64();
    send(d);
    drain("post_rst_vec", model(d));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
